// File: rtl/hazard_pkg.sv
// Shared types and limits for the decode hazard scoreboard.
package hazard_pkg;

  localparam int DEPTH_MIN   = 1;
  localparam int DEPTH_MAX   = 6;
  localparam int RW_MAX      = 8;
  localparam int FWD_REGFILE = 0;

  // dst is stored at RW_MAX bits so one typedef serves every register-file size
  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [RW_MAX-1:0] dst;
  } entry_t;

endpackage

// File: rtl/hazard_scoreboard_dst_tag_pipe.sv
// Destination-tag shift register: one entry per tracked stage, index 0 = youngest.
module dst_tag_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  entry_t               new_entry,
  output entry_t [DEPTH-1:0]   entries
);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  load_q;
  logic [RW_MAX-1:0] dst_q [DEPTH];

  // A flush squashes the instruction currently in DX before it can advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= new_entry.valid;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1] & ~(flush && (k == 1));
      end
    end
  end

  always_ff @(posedge clock) begin
    dst_q[0]  <= new_entry.dst;
    load_q[0] <= new_entry.is_load;
    for (int k = 1; k < DEPTH; k++) begin
      dst_q[k]  <= dst_q[k-1];
      load_q[k] <= load_q[k-1];
    end
  end

  always_comb begin
    entries = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries[k].valid   = vld_q[k];
      entries[k].is_load = load_q[k];
      entries[k].dst     = dst_q[k];
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: forwarding selects, load-use and mult/div stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 3,
  parameter int RW       = $clog2(NUM_REGS),
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [RW-1:0] src_a,
  input  logic [RW-1:0] src_b,
  input  logic          src_a_used,
  input  logic          src_b_used,
  input  logic [RW-1:0] dst,
  input  logic          dst_we,
  input  logic          dst_is_load,
  input  logic          dst_is_md,
  input  logic          md_done,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_a_sel,
  output logic [SW-1:0] fwd_b_sel,
  output logic          md_busy,
  output logic [SW-1:0] inflight
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH out of range");
  end
  if (RW > RW_MAX) begin : g_bad_rw
    $error("hazard_scoreboard: RW exceeds RW_MAX");
  end

  entry_t [DEPTH-1:0] entries;
  entry_t             new_entry;
  logic [DEPTH-1:0]   match_a;
  logic [DEPTH-1:0]   match_b;
  logic               md_busy_q;
  logic [RW-1:0]      md_dst_q;
  logic               load_use;
  logic               md_hazard;
  logic               accept;
  int unsigned        valid_cnt;

  function automatic logic src_hit(input entry_t e, input logic [RW-1:0] src, input logic used);
    return e.valid && used && (src != '0) && (e.dst == RW_MAX'(src));
  endfunction

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    match_a   = '0;
    match_b   = '0;
    fwd_a_sel = SW'(FWD_REGFILE);
    fwd_b_sel = SW'(FWD_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      match_a[k] = src_hit(entries[k], src_a, src_a_used);
      match_b[k] = src_hit(entries[k], src_b, src_b_used);
      if (match_a[k]) fwd_a_sel = SW'(k + 1);
      if (match_b[k]) fwd_b_sel = SW'(k + 1);
    end
  end

  assign load_use  = entries[0].is_load && (match_a[0] || match_b[0]);
  assign md_hazard = md_busy_q &&
                     ((src_a_used && (src_a != '0) && (src_a == md_dst_q)) ||
                      (src_b_used && (src_b != '0) && (src_b == md_dst_q)) ||
                      (dst_we && (dst == md_dst_q)) ||
                      dst_is_md);
  assign stall  = issue_valid && !flush && (load_use || md_hazard);
  assign accept = issue_valid && !flush && !stall;

  // Mult/div results bypass the tag pipe; they are tracked by the md record alone.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = accept && dst_we && (dst != '0) && !dst_is_md;
    new_entry.is_load = dst_is_load;
    new_entry.dst     = RW_MAX'(dst);
  end

  dst_tag_pipe #(.DEPTH(DEPTH)) u_dst_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .new_entry (new_entry),
    .entries   (entries)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy_q <= 1'b0;
    end else if (accept && dst_is_md) begin
      md_busy_q <= 1'b1;
    end else if (md_done) begin
      md_busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && dst_is_md) md_dst_q <= dst;
  end

  assign md_busy = md_busy_q;

  always_comb begin
    valid_cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries[k].valid) valid_cnt = valid_cnt + 1;
    end
    if (valid_cnt > DEPTH) valid_cnt = DEPTH;
    inflight = SW'(valid_cnt);
  end

endmodule
